// File: rtl/oam_dma.sv
`timescale 1ns/1ps
// oam_dma: sprite-memory DMA for the NES core.
// A CPU write to DMA_REG latches a source page, stalls the 6502 through ce,
// then copies LEN bytes from {page,idx} into PPU OAM starting at OAMADDR.
// Every state change is paced by the one-clk CPU cycle strobe `tick`.
module oam_dma #(
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter int unsigned LEN     = 256
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        tick,
  input  logic [15:0] eawr,
  input  logic [7:0]  dout,
  input  logic        wreq,
  input  logic [7:0]  din,
  input  logic [7:0]  oam_base,
  output logic        ce,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_t     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] base;
  logic [7:0] latch;
  logic       odd;

  // CPU-cycle parity: flips on every tick, DMA or not, so HALT knows
  // whether an extra alignment cycle is needed before the first read.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) odd <= 1'b0;
    else if (tick) odd <= ~odd;
  end

  // Transfer sequencer: trigger decode, source addressing, byte latch and
  // the single-clk OAM write strobe, all advancing only on tick.
  // NOTE: every register here is cleared by the asynchronous reset so an
  // aborted transfer leaves no stale strobe or address on the outputs.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      base     <= 8'h00;
      latch    <= 8'h00;
      dma_addr <= 16'h0000;
      oam_addr <= 8'h00;
      oam_data <= 8'h00;
      oam_we   <= 1'b0;
    end else begin
      // NOTE: default-low assignment makes oam_we a one-clk pulse without
      // any extra clear state.
      oam_we <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (wreq && (eawr == DMA_REG)) begin
              page  <= dout;
              base  <= oam_base;
              idx   <= 8'h00;
              state <= HALT;
            end
          end
          HALT: begin
            if (odd) begin
              state <= ALIGN;
            end else begin
              dma_addr <= {page, idx};
              state    <= READ;
            end
          end
          ALIGN: begin
            dma_addr <= {page, idx};
            state    <= READ;
          end
          READ: begin
            latch <= din;
            state <= WRITE;
          end
          WRITE: begin
            oam_we   <= 1'b1;
            oam_addr <= base + idx;
            oam_data <= latch;
            if (idx == LAST_IDX) begin
              state <= IDLE;
            end else begin
              idx      <= idx + 8'd1;
              dma_addr <= {page, idx + 8'd1};
              state    <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Bus ownership flags decode straight from the state register.
  // NOTE: continuous assigns from a register cannot infer a latch; every
  // output here has a value in every state.
  assign ce     = (state == IDLE);
  assign busy   = (state != IDLE);
  assign dma_rd = (state == READ);

endmodule

// File: tb/tb_oam_dma.sv
`timescale 1ns/1ps
// tb_oam_dma: directed-plus-random bench for oam_dma.
// The reference model is a byte-array CPU memory and OAM image: a transfer
// of page P at base B must write OAM[(B+i) mod 256] = MEM[P*256+i] in order,
// stalling the CPU for 513 ticks, plus one when the HALT cycle is odd.
module tb_oam_dma;

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam int          TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] eawr = 16'h0000;
  logic [7:0]  dout = 8'h00;
  logic        wreq = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  oam_base = 8'h00;
  logic        ce;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         tick_cnt = 0;
  int         ce_low_ticks = 0;
  int         div = 0;
  bit         tick_en = 1'b1;

  oam_dma #(.DMA_REG(DMA_REG), .LEN(256)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .tick     (tick),
    .eawr     (eawr),
    .dout     (dout),
    .wreq     (wreq),
    .din      (din),
    .oam_base (oam_base),
    .ce       (ce),
    .dma_rd   (dma_rd),
    .dma_addr (dma_addr),
    .oam_addr (oam_addr),
    .oam_data (oam_data),
    .oam_we   (oam_we),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // CPU cycle strobe, changed on the falling edge; tick_en freezes it.
  always @(negedge clk) begin
    if (tick_en && div == TICK_DIV - 1) begin
      tick = 1'b1;
      div  = 0;
    end else begin
      tick = 1'b0;
      if (tick_en) div = div + 1;
    end
  end

  // Synchronous CPU memory: data valid one clk after the address.
  always @(posedge clk) din <= mem[dma_addr];

  // OAM image and write log.
  always @(posedge clk) begin
    if (oam_we) begin
      oam[oam_addr] <= oam_data;
      wr_addr_q.push_back(oam_addr);
      wr_data_q.push_back(oam_data);
    end
  end

  // CPU cycles since reset; parity of this count is the DMA's view of odd.
  always @(posedge clk or posedge RESET) begin
    if (RESET) tick_cnt <= 0;
    else if (tick) tick_cnt <= tick_cnt + 1;
  end

  // CPU cycles lost to the stall.
  always @(posedge clk) begin
    if (tick && !ce && !RESET) ce_low_ticks <= ce_low_ticks + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (tick) break;
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // One CPU bus cycle committed on a tick; want_odd selects the parity the
  // following (HALT) tick will see, -1 for any.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic w,
                           input int want_odd, output int k);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk); #1;
      if (tick && (want_odd < 0 || ((tick_cnt + 1) % 2) == want_odd)) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL cpu_cycle no usable tick observed=0 expected=1");
    end
    k    = tick_cnt;
    eawr = a;
    dout = d;
    wreq = w;
    @(posedge clk); #1;
    wreq = 1'b0;
  endtask

  task automatic start_dma(input string tag, input logic [7:0] pg, input logic [7:0] bs,
                           input int want_odd, output int q0, output int ce0, output int odd_exp);
    int  k;
    int  n;
    bit  seen;
    oam_base = bs;
    q0  = wr_addr_q.size();
    ce0 = ce_low_ticks;
    cpu_cycle(DMA_REG, pg, 1'b1, want_odd, k);
    odd_exp = (k + 1) % 2;
    check({tag, " busy_after_trigger"}, busy, 1);
    check({tag, " ce_after_trigger"}, ce, 0);
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      wait_tick(); #1;
      n++;
      seen = dma_rd;
    end
    check({tag, " ticks_to_first_read"}, n, 1 + odd_exp);
    check({tag, " first_dma_addr"}, dma_addr, {pg, 8'h00});
  endtask

  task automatic finish_dma(input string tag, input logic [7:0] pg, input logic [7:0] bs,
                            input int q0, input int ce0, input int odd_exp);
    int         errs;
    bit         done;
    logic [7:0] ii;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk); #1;
      done = !busy;
    end
    @(posedge clk); #1;
    check({tag, " completes"}, done, 1);
    check({tag, " ce_released"}, ce, 1);
    check({tag, " write_count"}, wr_addr_q.size() - q0, 256);
    check({tag, " stall_ticks"}, ce_low_ticks - ce0, 513 + odd_exp);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      ii = 8'(i);
      if (q0 + i < wr_addr_q.size()) begin
        if (wr_addr_q[q0 + i] !== 8'(bs + ii)) errs++;
        if (wr_data_q[q0 + i] !== mem[{pg, ii}]) errs++;
      end else begin
        errs++;
      end
      if (oam[8'(bs + ii)] !== mem[{pg, ii}]) errs++;
    end
    check({tag, " content_errors"}, errs, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         q0;
    int         ce0;
    int         odd_exp;
    int         errs;
    int         n0;
    bit         hit;
    logic [7:0] pg;
    logic [7:0] bs;
    logic [7:0] ii;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    // Reset state.
    #12;
    check("reset ce", ce, 1);
    check("reset busy", busy, 0);
    check("reset dma_rd", dma_rd, 0);
    check("reset oam_we", oam_we, 0);
    check("reset dma_addr", dma_addr, 16'h0000);
    check("reset oam_addr", oam_addr, 8'h00);
    check("reset oam_data", oam_data, 8'h00);
    @(negedge clk);
    RESET = 1'b0;

    // Neighbouring addresses and a read of the trigger address.
    cpu_cycle(16'h4013, 8'h02, 1'b1, -1, k);
    check("nontrig 4013 busy", busy, 0);
    cpu_cycle(16'h4015, 8'h02, 1'b1, -1, k);
    check("nontrig 4015 busy", busy, 0);
    cpu_cycle(16'h2004, 8'h02, 1'b1, -1, k);
    check("nontrig 2004 busy", busy, 0);
    cpu_cycle(DMA_REG, 8'h02, 1'b0, -1, k);
    check("nontrig read4014 busy", busy, 0);
    wait_ticks(10); #1;
    check("nontrig busy_later", busy, 0);
    check("nontrig no_writes", wr_addr_q.size(), 0);

    // Even alignment, page 2 preloaded with i^5A.
    start_dma("even", 8'h02, 8'h00, 0, q0, ce0, odd_exp);
    finish_dma("even", 8'h02, 8'h00, q0, ce0, odd_exp);
    errs = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) errs++;
    check("even oam_pattern_errors", errs, 0);

    // Odd alignment.
    start_dma("odd", 8'h02, 8'h00, 1, q0, ce0, odd_exp);
    finish_dma("odd", 8'h02, 8'h00, q0, ce0, odd_exp);

    // Wrap from F0, with OAMADDR moved and a forced re-trigger mid-transfer.
    start_dma("wrap", 8'h03, 8'hF0, -1, q0, ce0, odd_exp);
    oam_base = 8'h11;
    cpu_cycle(DMA_REG, 8'h07, 1'b1, -1, k);
    finish_dma("wrap", 8'h03, 8'hF0, q0, ce0, odd_exp);
    check("wrap first_addr", wr_addr_q[q0], 8'hF0);
    check("wrap first_data", wr_data_q[q0], mem[16'h0300]);
    check("wrap write16_addr", wr_addr_q[q0 + 16], 8'h00);
    check("wrap last_addr", wr_addr_q[q0 + 255], 8'hEF);
    check("wrap last_data", wr_data_q[q0 + 255], mem[16'h03FF]);

    // Random pages, bases and alignment.
    for (int r = 0; r < 3; r++) begin
      pg = 8'($urandom);
      bs = 8'($urandom);
      wait_ticks(int'($urandom_range(0, 5)));
      start_dma("random", pg, bs, -1, q0, ce0, odd_exp);
      if ($urandom_range(0, 1) == 1) cpu_cycle(DMA_REG, ~pg, 1'b1, -1, k);
      finish_dma("random", pg, bs, q0, ce0, odd_exp);
    end

    // Tick held off for 50 clks in the middle of a READ.
    pg = 8'($urandom);
    bs = 8'($urandom);
    start_dma("stall", pg, bs, -1, q0, ce0, odd_exp);
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk); #1;
      if ((wr_addr_q.size() - q0) >= 10 && dma_rd && !tick && !oam_we) hit = 1'b1;
    end
    tick_en = 1'b0;
    n0 = wr_addr_q.size() - q0;
    ii = 8'(n0);
    repeat (50) @(posedge clk);
    #1;
    check("stall found_read", hit, 1);
    check("stall dma_addr_held", dma_addr, {pg, ii});
    check("stall dma_rd_held", dma_rd, 1);
    check("stall busy_held", busy, 1);
    check("stall no_writes", wr_addr_q.size() - q0, n0);
    tick_en = 1'b1;
    finish_dma("stall", pg, bs, q0, ce0, odd_exp);

    // Reset after 100 OAM writes, then a fresh transfer.
    pg = 8'($urandom);
    bs = 8'($urandom);
    start_dma("rstmid", pg, bs, -1, q0, ce0, odd_exp);
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk); #1;
      if ((wr_addr_q.size() - q0) >= 100) hit = 1'b1;
    end
    RESET = 1'b1;
    #1;
    check("rstmid reached100", hit, 1);
    check("rstmid async_ce", ce, 1);
    check("rstmid async_busy", busy, 0);
    check("rstmid async_dma_rd", dma_rd, 0);
    check("rstmid async_oam_we", oam_we, 0);
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    wait_ticks(40); #1;
    check("rstmid no_more_writes", wr_addr_q.size() - q0, 100);
    check("rstmid idle", busy, 0);
    pg = 8'($urandom);
    bs = 8'($urandom);
    start_dma("restart", pg, bs, -1, q0, ce0, odd_exp);
    finish_dma("restart", pg, bs, q0, ce0, odd_exp);

    // Trigger while reset is held: reset wins.
    RESET = 1'b1;
    cpu_cycle(DMA_REG, 8'h02, 1'b1, -1, k);
    check("rsttrig busy", busy, 0);
    check("rsttrig ce", ce, 1);
    @(negedge clk);
    RESET = 1'b0;
    wait_ticks(4); #1;
    check("rsttrig busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-memory DMA controller for the NES core. It decodes the CPU write to $4014 and then stalls the 6502 through its `CE` input. It copies 256 bytes from CPU page `$XX00–$XXFF` (SRAM or ROM, via the normal CPU read mux) into the PPU's 256-byte OAM. It sits between the CPU bus (`eawr`/`dout`/`wreq`/`din`) and the PPU OAM write port, with all sequencing paced by the CPU cycle strobe.

## Interface
- `DMA_REG`, default 16'h4014, CPU address that triggers DMA.
- `LEN`, default 256, bytes per transfer; fixed power of two, 256 only supported.
- `clk`  in  1  system clock, 100 MHz; the only clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-`clk`-wide pulse per CPU cycle, coincident with the CPU clock edge that commits `wreq`.
- `eawr`  in  16  CPU effective write address.
- `dout`  in  8  CPU write data; gives the page number.
- `wreq`  in  1  CPU write request.
- `din`  in  8  read data from the CPU memory mux; valid 1 `clk` after `dma_addr` changes.
- `oam_base`  in  8  current PPU OAMADDR; sampled at trigger.
- `ce`  out  1  CPU clock enable; 0 while DMA owns the bus.
- `dma_rd`  out  1  1 when `dma_addr` drives the CPU address mux.
- `dma_addr`  out  16  source address `{page, idx}`.
- `oam_addr`  out  8  OAM write address.
- `oam_data`  out  8  OAM write data.
- `oam_we`  out  1  one-`clk` OAM write strobe.
- `busy`  out  1  DMA in progress.

## Operation
- Registers: `state`, `page`[7:0], `idx`[7:0], `base`[7:0], `latch`[7:0], `odd` (CPU-cycle parity).
- `odd` toggles on every `tick`, including during DMA, and is 0 after reset.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- All transitions occur on `tick` only.
- IDLE: on `tick & wreq & eawr==DMA_REG`:
  - `page<=dout`, `base<=oam_base`, `idx<=0`, go HALT.
- HALT (1 CPU cycle):
  - If `odd` is 1 at this tick, go ALIGN; otherwise go READ.
- ALIGN (1 CPU cycle): dummy cycle, go READ.
- READ:
  - `dma_rd=1` and `dma_addr={page,idx}` throughout.
  - On `tick`: `latch<=din`, go WRITE.
- WRITE:
  - On `tick`: pulse `oam_we` for exactly one `clk` with `oam_addr=base+idx` (mod 256) and `oam_data=latch`.
  - If `idx==LEN-1`, go IDLE; else `idx<=idx+1` and go READ.
- `ce = (state==IDLE)`.
- `busy = (state!=IDLE)`.
- `dma_rd = (state==READ)`.
- Outside READ, `dma_addr` holds its last value.
- Total stall: 513 CPU cycles when `odd` is 0 at the HALT tick, 514 otherwise.
- Writes to DMA_REG while busy are ignored. They cannot occur while `ce=0`, but a bench may force them.
- `oam_addr` wraps modulo 256: base 8'hF0 writes F0..FF, then 00..EF.

## Timing
- Reset values: `ce=1`, `busy=0`, `dma_rd=0`, `oam_we=0`, `dma_addr=0`, `oam_addr=0`, `oam_data=0`, `odd=0`, `state=IDLE`.
- `ce` falls on the `clk` after the trigger tick, so the triggering CPU write completes.
- `ce` rises on the `clk` after the final WRITE tick, so the CPU resumes on the next `tick`.
- READ latency:
  - `dma_addr` is stable for a full CPU cycle.
  - `din` is sampled at the ending `tick`, which covers the 1-clk synchronous SRAM/ROM latency.
- `oam_we` asserts in the `clk` following the WRITE tick and lasts 1 `clk`.
- `oam_addr`/`oam_data` are stable in that same `clk`.
- RESET asserted mid-transfer: return to IDLE immediately (async).
  - `ce=1`, no further `oam_we`.
  - OAM is left partially written.
- `tick` absent: the FSM freezes; no timeout.
- Trigger and RESET in the same cycle: RESET wins.

## Test plan
- Even alignment:
  - Stimulus: preload SRAM 0x0200+i = i^8'h5A; write 8'h02 to $4014 with `odd`=0 at HALT.
  - Required: 256 `oam_we` pulses, OAM[i]=i^5A, `ce` low for exactly 513 ticks.
- Odd alignment:
  - Stimulus: same, shifted one tick so `odd`=1 at HALT.
  - Required: `ce` low for 514 ticks; first READ occurs 2 ticks after trigger.
- Wrap:
  - Stimulus: `oam_base`=8'hF0, page 8'h03.
  - Required: first write `oam_addr`=F0 with data from 0x0300; write 16 at `oam_addr`=00; last write at EF with data from 0x03FF.
- Non-trigger:
  - Stimulus: writes to $4013, $4015, $2004, plus a read (`wreq`=0) of $4014.
  - Required: `busy` stays 0, no `oam_we`.
- Reset mid-op:
  - Stimulus: assert RESET after 100 OAM writes.
  - Required: `ce`=1, `busy`=0 asynchronously; no further `oam_we`; a new trigger then restarts from `idx`=0.
- Stalled tick:
  - Stimulus: hold `tick`=0 for 50 clks mid-READ.
  - Required: `dma_addr` and state unchanged, no `oam_we`; the transfer resumes correctly.
